// File: rtl/data_memory_ws.sv
// Wait-state data memory with busy/valid handshake, self-clear sweep after reset,
// read-during-write policy and out-of-range detection. Optional parity: DMEM_PARITY_EN.
module data_memory_ws #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned RDW_MODE    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_drd,
  input  logic              en_dwr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_din,
  output logic [DATA_W-1:0] mem_dout,
  output logic              mem_valid,
  output logic              mem_busy,
  output logic              mem_err,
  output logic              mem_perr
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_WAIT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] sweep_q, sweep_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_din_q, req_din_d;
  logic              req_rd_q, req_rd_d;
  logic              req_wr_q, req_wr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              perr_q, perr_d;
  logic              busy_q, busy_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              done_c;
  logic              acc_rd_c;
  logic              acc_wr_c;
  logic [ADDR_W-1:0] acc_addr_c;
  logic [DATA_W-1:0] acc_din_c;
  logic              acc_oor_c;
  logic [IDX_W-1:0]  acc_idx_c;
  logic [DATA_W-1:0] rd_word_c;
  logic              rd_perr_c;
  logic              wt_c;
  logic              we_c;
  logic [IDX_W-1:0]  we_idx_c;
  logic [DATA_W-1:0] we_data_c;

  // Select which access completes this edge: live inputs (zero wait) or the latched request
  always_comb begin
    done_c     = 1'b0;
    acc_rd_c   = req_rd_q;
    acc_wr_c   = req_wr_q;
    acc_addr_c = req_addr_q;
    acc_din_c  = req_din_q;
    if (state_q == ST_IDLE && WAIT_STATES == 0) begin
      done_c     = en_drd | en_dwr;
      acc_rd_c   = en_drd;
      acc_wr_c   = en_dwr;
      acc_addr_c = mem_addr;
      acc_din_c  = mem_din;
    end else if (state_q == ST_WAIT && cnt_q == '0) begin
      done_c = 1'b1;
    end
  end

  assign acc_oor_c = 32'(acc_addr_c) >= DEPTH;
  assign acc_idx_c = IDX_W'(acc_addr_c);
  assign rd_word_c = acc_oor_c ? '0 : mem_q[acc_idx_c];
  assign wt_c      = acc_wr_c && (RDW_MODE != 0);

`ifdef DMEM_PARITY_EN
  logic par_q [DEPTH];
  logic we_par_c;

  assign rd_perr_c = !acc_oor_c && ((^rd_word_c) != par_q[acc_idx_c]);
  assign we_par_c  = (state_q == ST_CLEAR) ? 1'b0 : ^we_data_c;

  always_ff @(posedge clk) begin
    if (we_c && !rst) par_q[we_idx_c] <= we_par_c;
  end
`else
  assign rd_perr_c = 1'b0;
`endif

  // Next-state, request latch, completion outputs and array write port
  always_comb begin
    state_d    = state_q;
    sweep_d    = sweep_q;
    cnt_d      = cnt_q;
    req_addr_d = req_addr_q;
    req_din_d  = req_din_q;
    req_rd_d   = req_rd_q;
    req_wr_d   = req_wr_q;
    dout_d     = dout_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    perr_d     = 1'b0;
    we_c       = 1'b0;
    we_idx_c   = IDX_W'(sweep_q);
    we_data_c  = '0;

    case (state_q)
      ST_CLEAR: begin
        we_c = 1'b1;
        if (sweep_q == ADDR_W'(DEPTH - 1)) state_d = ST_IDLE;
        else sweep_d = sweep_q + ADDR_W'(1);
      end
      ST_IDLE: begin
        if (en_drd || en_dwr) begin
          req_addr_d = mem_addr;
          req_din_d  = mem_din;
          req_rd_d   = en_drd;
          req_wr_d   = en_dwr;
          if (WAIT_STATES != 0) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(WAIT_STATES - 1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else state_d = ST_IDLE;
      end
      default: state_d = ST_CLEAR;
    endcase

    if (done_c) begin
      err_d = acc_oor_c;
      if (acc_wr_c && !acc_oor_c) begin
        we_c      = 1'b1;
        we_idx_c  = acc_idx_c;
        we_data_c = acc_din_c;
      end
      if (acc_rd_c) begin
        valid_d = 1'b1;
        if (!acc_oor_c) begin
          dout_d = wt_c ? acc_din_c : rd_word_c;
          perr_d = rd_perr_c && !wt_c;
        end
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      sweep_q    <= '0;
      cnt_q      <= '0;
      req_addr_q <= '0;
      req_din_q  <= '0;
      req_rd_q   <= 1'b0;
      req_wr_q   <= 1'b0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      perr_q     <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      sweep_q    <= sweep_d;
      cnt_q      <= cnt_d;
      req_addr_q <= req_addr_d;
      req_din_q  <= req_din_d;
      req_rd_q   <= req_rd_d;
      req_wr_q   <= req_wr_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      perr_q     <= perr_d;
      busy_q     <= busy_d;
    end
  end

  // Storage array; no reset, the clear sweep initialises it
  always_ff @(posedge clk) begin
    if (we_c && !rst) mem_q[we_idx_c] <= we_data_c;
  end

  assign mem_dout  = dout_q;
  assign mem_valid = valid_q;
  assign mem_err   = err_q;
  assign mem_perr  = perr_q;
  assign mem_busy  = busy_q;

endmodule

// File: tb/tb_data_memory_ws.sv
// Directed bench for data_memory_ws: three instances cover zero/three wait states,
// both read-during-write modes and a non-power-of-two depth.
module tb_data_memory_ws;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a  [3];
  logic       rd_a   [3];
  logic       wr_a   [3];
  logic [7:0] addr_a [3];
  logic [7:0] din_a  [3];
  wire  [7:0] dout_a [3];
  wire        valid_a[3];
  wire        busy_a [3];
  wire        err_a  [3];
  wire        perr_a [3];

  int n_checks = 0;
  int n_errors = 0;

  data_memory_ws #(.DEPTH(256), .WAIT_STATES(0), .RDW_MODE(0)) u0 (
    .clk(clk), .rst(rst_a[0]), .en_drd(rd_a[0]), .en_dwr(wr_a[0]),
    .mem_addr(addr_a[0]), .mem_din(din_a[0]), .mem_dout(dout_a[0]),
    .mem_valid(valid_a[0]), .mem_busy(busy_a[0]), .mem_err(err_a[0]), .mem_perr(perr_a[0]));

  data_memory_ws #(.DEPTH(256), .WAIT_STATES(3), .RDW_MODE(1)) u1 (
    .clk(clk), .rst(rst_a[1]), .en_drd(rd_a[1]), .en_dwr(wr_a[1]),
    .mem_addr(addr_a[1]), .mem_din(din_a[1]), .mem_dout(dout_a[1]),
    .mem_valid(valid_a[1]), .mem_busy(busy_a[1]), .mem_err(err_a[1]), .mem_perr(perr_a[1]));

  data_memory_ws #(.DEPTH(200), .WAIT_STATES(0), .RDW_MODE(0)) u2 (
    .clk(clk), .rst(rst_a[2]), .en_drd(rd_a[2]), .en_dwr(wr_a[2]),
    .mem_addr(addr_a[2]), .mem_din(din_a[2]), .mem_dout(dout_a[2]),
    .mem_valid(valid_a[2]), .mem_busy(busy_a[2]), .mem_err(err_a[2]), .mem_perr(perr_a[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one request at a negedge; returns at the negedge after the accept edge
  task automatic req(input int i, input logic rd, input logic wr,
                     input logic [7:0] a, input logic [7:0] d);
    rd_a[i] = rd; wr_a[i] = wr; addr_a[i] = a; din_a[i] = d;
    @(negedge clk);
    rd_a[i] = 1'b0; wr_a[i] = 1'b0;
  endtask

  task automatic wait_valid(input int i, input int budget);
    int n = 0;
    while (!valid_a[i] && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!valid_a[i]) check("valid_timeout", 32'(valid_a[i]), 32'd1);
  endtask

  task automatic wait_idle(input int i, input int budget);
    int n = 0;
    while (busy_a[i] && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy_a[i]) check("idle_timeout", 32'(busy_a[i]), 32'd0);
  endtask

  int busy_cnt [3];

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_a[i] = 1'b1; rd_a[i] = 1'b0; wr_a[i] = 1'b0; addr_a[i] = '0; din_a[i] = '0;
      busy_cnt[i] = 0;
    end
    repeat (3) @(negedge clk);

    check("rst_dout",  32'(dout_a[0]),  32'h00);
    check("rst_valid", 32'(valid_a[0]), 32'd0);
    check("rst_err",   32'(err_a[0]),   32'd0);
    check("rst_perr",  32'(perr_a[0]),  32'd0);
    check("rst_busy",  32'(busy_a[0]),  32'd1);

    // Sweep length: busy cycles counted from reset release
    for (int i = 0; i < 3; i++) rst_a[i] = 1'b0;
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < 3; i++) busy_cnt[i] += int'(busy_a[i]);
      @(negedge clk);
    end
    check("sweep_len_u0", 32'(busy_cnt[0]), 32'd256);
    check("sweep_len_u1", 32'(busy_cnt[1]), 32'd256);
    check("sweep_len_u2", 32'(busy_cnt[2]), 32'd200);

    // Cleared words read back zero
    req(0, 1'b1, 1'b0, 8'h00, 8'h00);
    check("clr00_valid", 32'(valid_a[0]), 32'd1);
    check("clr00_dout",  32'(dout_a[0]),  32'h00);
    req(0, 1'b1, 1'b0, 8'h7F, 8'h00);
    check("clr7f_dout",  32'(dout_a[0]),  32'h00);
    req(0, 1'b1, 1'b0, 8'hFF, 8'h00);
    check("clrff_valid", 32'(valid_a[0]), 32'd1);
    check("clrff_dout",  32'(dout_a[0]),  32'h00);
    check("clrff_err",   32'(err_a[0]),   32'd0);

    // Zero wait states: write then read, back-to-back reads
    req(0, 1'b0, 1'b1, 8'h10, 8'hA5);
    check("wr_novalid", 32'(valid_a[0]), 32'd0);
    check("wr_busy",    32'(busy_a[0]),  32'd0);
    req(0, 1'b1, 1'b0, 8'h10, 8'h00);
    check("rd10_valid", 32'(valid_a[0]), 32'd1);
    check("rd10_dout",  32'(dout_a[0]),  32'hA5);
    req(0, 1'b0, 1'b1, 8'h11, 8'h5A);
    rd_a[0] = 1'b1; addr_a[0] = 8'h10;
    @(negedge clk);
    check("b2b0_valid", 32'(valid_a[0]), 32'd1);
    check("b2b0_dout",  32'(dout_a[0]),  32'hA5);
    addr_a[0] = 8'h11;
    @(negedge clk);
    rd_a[0] = 1'b0;
    check("b2b1_valid", 32'(valid_a[0]), 32'd1);
    check("b2b1_dout",  32'(dout_a[0]),  32'h5A);
    @(negedge clk);
    check("b2b_end",    32'(valid_a[0]), 32'd0);
    check("hold_dout",  32'(dout_a[0]),  32'h5A);

    // Read-during-write, old-data mode
    req(0, 1'b0, 1'b1, 8'h20, 8'h11);
    req(0, 1'b1, 1'b1, 8'h20, 8'h3C);
    check("rdw0_dout",  32'(dout_a[0]),  32'h11);
    req(0, 1'b1, 1'b0, 8'h20, 8'h00);
    check("rdw0_after", 32'(dout_a[0]),  32'h3C);

    // Three wait states: busy window, ignored second request, single valid
    req(1, 1'b0, 1'b1, 8'h20, 8'h11);
    wait_idle(1, 10);
    rd_a[1] = 1'b1; addr_a[1] = 8'h20;
    @(negedge clk);
    check("ws_k_busy",   32'(busy_a[1]),  32'd1);
    check("ws_k_valid",  32'(valid_a[1]), 32'd0);
    @(negedge clk);
    rd_a[1] = 1'b0;
    check("ws_k1_busy",  32'(busy_a[1]),  32'd1);
    @(negedge clk);
    check("ws_k2_busy",  32'(busy_a[1]),  32'd1);
    check("ws_k2_valid", 32'(valid_a[1]), 32'd0);
    @(negedge clk);
    check("ws_k3_valid", 32'(valid_a[1]), 32'd1);
    check("ws_k3_busy",  32'(busy_a[1]),  32'd0);
    check("ws_k3_dout",  32'(dout_a[1]),  32'h11);
    @(negedge clk);
    check("ws_noextra",  32'(valid_a[1]), 32'd0);

    // Read-during-write, write-through mode
    req(1, 1'b1, 1'b1, 8'h20, 8'h3C);
    wait_valid(1, 10);
    check("rdw1_dout",  32'(dout_a[1]), 32'h3C);
    @(negedge clk);
    req(1, 1'b1, 1'b0, 8'h20, 8'h00);
    wait_valid(1, 10);
    check("rdw1_after", 32'(dout_a[1]), 32'h3C);
    @(negedge clk);

    // Out-of-range on DEPTH=200
    req(2, 1'b0, 1'b1, 8'h05, 8'h42);
    req(2, 1'b1, 1'b0, 8'h05, 8'h00);
    check("oor_pre_dout", 32'(dout_a[2]), 32'h42);
    req(2, 1'b0, 1'b1, 8'hC8, 8'h55);
    check("oor_wr_err",   32'(err_a[2]),   32'd1);
    check("oor_wr_valid", 32'(valid_a[2]), 32'd0);
    req(2, 1'b1, 1'b0, 8'hC8, 8'h00);
    check("oor_rd_err",   32'(err_a[2]),   32'd1);
    check("oor_rd_valid", 32'(valid_a[2]), 32'd1);
    check("oor_rd_dout",  32'(dout_a[2]),  32'h42);
    req(2, 1'b0, 1'b1, 8'hC7, 8'h99);
    check("last_wr_err",  32'(err_a[2]),   32'd0);
    req(2, 1'b1, 1'b0, 8'hC7, 8'h00);
    check("last_rd_dout", 32'(dout_a[2]),  32'h99);
    check("last_rd_err",  32'(err_a[2]),   32'd0);
    req(2, 1'b1, 1'b0, 8'h00, 8'h00);
    check("nowrap_dout",  32'(dout_a[2]),  32'h00);

    // Reset during a pending write drops it and restarts the sweep
    req(1, 1'b0, 1'b1, 8'h05, 8'h77);
    rst_a[1] = 1'b1;
    @(negedge clk);
    rst_a[1] = 1'b0;
    check("rst_mid_busy", 32'(busy_a[1]), 32'd1);
    busy_cnt[1] = 0;
    for (int k = 0; k < 300; k++) begin
      busy_cnt[1] += int'(busy_a[1]);
      @(negedge clk);
    end
    check("resweep_len", 32'(busy_cnt[1]), 32'd256);
    req(1, 1'b1, 1'b0, 8'h05, 8'h00);
    wait_valid(1, 10);
    check("lost_write", 32'(dout_a[1]), 32'h00);
    @(negedge clk);

`ifdef DMEM_PARITY_EN
    req(0, 1'b0, 1'b1, 8'h30, 8'h0F);
    u0.mem_q[48] = 8'h0E;
    req(0, 1'b1, 1'b0, 8'h30, 8'h00);
    check("par_valid", 32'(valid_a[0]), 32'd1);
    check("par_perr",  32'(perr_a[0]),  32'd1);
    check("par_dout",  32'(dout_a[0]),  32'h0E);
`else
    req(0, 1'b1, 1'b0, 8'h10, 8'h00);
    check("noparity_perr", 32'(perr_a[0]), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
